// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Holds the receiver FSM encoding and the data-width decode.
package uart_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // 2-bit width code to data bit count (5..8)
   function automatic logic [3:0] data_bits(input logic [1:0] code);
      return 4'd5 + {2'b00, code};
   endfunction

endpackage

// File: rtl/parity.sv
// parity: XOR reduction of a data word.
// Yields 1 when the word holds an odd number of ones.
module parity #(
   parameter int W = 8
) (
   input  logic [W-1:0] data_i,
   output logic         parity_o
);

   assign parity_o = ^data_i;

endmodule

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line.
// A third flop delays rx_s so its falling edge can be detected.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q, dly_d;

   // next values: shift the line through the chain
   always_comb begin
      meta_d = rx_i;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   // line idles high, so the chain resets to 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign rx_s_o = sync_q;
   assign fall_o = dly_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive stage with a
// valid/ack holding register and parity/frame/overrun status.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_en_i,
   input  logic       tick_i,
   input  logic       rx_i,
   input  logic [1:0] data_bit_num_i,
   input  logic       parity_en_i,
   input  logic       parity_type_i,
   input  logic       stop_bit_num_i,
   input  logic       rd_ack_i,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       rx_done_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_err_o,
   output logic       rts_no
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   logic rx_s;
   logic rx_fall;

   uart_rx_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .rx_i   (rx_i),
      .rx_s_o (rx_s),
      .fall_o (rx_fall)
   );

   rx_state_t     state_q, state_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_bit_q, par_bit_d;
   logic          ferr_acc_q, ferr_acc_d;

   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          rts_q, rts_d;

   logic          sample;
   logic          data_last;
   logic          complete;
   logic          ferr_new;
   logic          par_calc;
   logic          perr_new;

   parity #(.W(8)) u_parity (
      .data_i   (shreg_q),
      .parity_o (par_calc)
   );

   // mid-bit sample strobe: half a bit in START, full bit elsewhere
   always_comb begin
      sample = 1'b0;
      if (tick_i) begin
         if (state_q == RX_START) begin
            sample = (tick_cnt_q == HALF_LAST);
         end else begin
            sample = (tick_cnt_q == FULL_LAST);
         end
      end
      data_last = (({1'b0, bit_cnt_q} + 4'd1) == data_bits(data_bit_num_i));
      ferr_new  = ferr_acc_q | ~rx_s;
      perr_new  = parity_en_i & (par_bit_q ^ par_calc ^ parity_type_i);
   end

   // frame FSM: tick counting, bit sampling and completion detect
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_bit_d  = par_bit_q;
      ferr_acc_d = ferr_acc_q;
      complete   = 1'b0;

      if (tick_i && state_q != RX_IDLE) begin
         if (state_q == RX_START && tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end

      unique case (state_q)
         RX_IDLE: begin
            if (rx_fall && rx_en_i) begin
               state_d    = RX_START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               shreg_d    = '0;
               ferr_acc_d = 1'b0;
            end
         end
         RX_START: begin
            if (sample) begin
               state_d   = rx_s ? RX_IDLE : RX_DATA;
               bit_cnt_d = '0;
            end
         end
         RX_DATA: begin
            if (sample) begin
               shreg_d[bit_cnt_q] = rx_s;
               if (data_last) begin
                  bit_cnt_d = '0;
                  state_d   = parity_en_i ? RX_PARITY : RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         RX_PARITY: begin
            if (sample) begin
               par_bit_d = rx_s;
               bit_cnt_d = '0;
               state_d   = RX_STOP;
            end
         end
         RX_STOP: begin
            if (sample) begin
               ferr_acc_d = ferr_new;
               if (bit_cnt_q[0] == stop_bit_num_i) begin
                  complete = 1'b1;
                  state_d  = RX_IDLE;
               end else begin
                  bit_cnt_d = 3'd1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase

      if (!rx_en_i) begin
         state_d  = RX_IDLE;
         complete = 1'b0;
      end
   end

   // holding register, status flags and flow control
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      rts_d   = ~(rx_en_i & ~valid_q);

      if (complete) begin
         done_d = 1'b1;
         if (!valid_q || rd_ack_i) begin
            data_d  = shreg_q;
            perr_d  = perr_new;
            ferr_d  = ferr_new;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (rd_ack_i && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RX_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_bit_q  <= 1'b0;
         ferr_acc_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         rts_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_bit_q  <= par_bit_d;
         ferr_acc_q <= ferr_acc_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         rts_q      <= rts_d;
      end
   end

   assign data_o        = data_q;
   assign data_valid_o  = valid_q;
   assign rx_done_o     = done_q;
   assign parity_err_o  = perr_q;
   assign frame_err_o   = ferr_q;
   assign overrun_err_o = ovr_q;
   assign rts_no        = rts_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver with a
// scoreboard queue checked by an independent completion monitor.
module tb_uart_receiver;

   logic       clk;
   logic       reset;
   logic       rx_en_i;
   logic       tick_i;
   logic       rx_i;
   logic [1:0] data_bit_num_i;
   logic       parity_en_i;
   logic       parity_type_i;
   logic       stop_bit_num_i;
   logic       rd_ack_i;
   logic [7:0] data_o;
   logic       data_valid_o;
   logic       rx_done_o;
   logic       parity_err_o;
   logic       frame_err_o;
   logic       overrun_err_o;
   logic       rts_no;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ov;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   int   d0;
   int   tph = 0;

   localparam int BIT_CLK = 64;

   uart_receiver #(.OVERSAMPLE(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .rx_en_i        (rx_en_i),
      .tick_i         (tick_i),
      .rx_i           (rx_i),
      .data_bit_num_i (data_bit_num_i),
      .parity_en_i    (parity_en_i),
      .parity_type_i  (parity_type_i),
      .stop_bit_num_i (stop_bit_num_i),
      .rd_ack_i       (rd_ack_i),
      .data_o         (data_o),
      .data_valid_o   (data_valid_o),
      .rx_done_o      (rx_done_o),
      .parity_err_o   (parity_err_o),
      .frame_err_o    (frame_err_o),
      .overrun_err_o  (overrun_err_o),
      .rts_no         (rts_no)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one tick every 4 clocks, changed just after the rising edge
   initial begin
      tick_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_i = (tph == 3);
         tph = (tph + 1) % 4;
      end
   end

   // completion monitor: pops the scoreboard on each rx_done_o pulse
   always @(negedge clk) begin
      if (rx_done_o === 1'b1) begin
         done_cnt++;
         vectors++;
         if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done data_o=%h", data_o);
         end else begin
            mon_e = sbq.pop_front();
            if ({data_o, parity_err_o, frame_err_o, overrun_err_o,
                 data_valid_o} !==
                {mon_e.d, mon_e.pe, mon_e.fe, mon_e.ov, 1'b1}) begin
               miscompares++;
               $display("FAIL frame got d=%h pe=%b fe=%b ov=%b v=%b exp d=%h pe=%b fe=%b ov=%b v=1",
                        data_o, parity_err_o, frame_err_o,
                        overrun_err_o, data_valid_o,
                        mon_e.d, mon_e.pe, mon_e.fe, mon_e.ov);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic pe,
                       input logic fe, input logic ov);
      exp_t e;
      e.d = d;
      e.pe = pe;
      e.fe = fe;
      e.ov = ov;
      sbq.push_back(e);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // stop on a falling edge whose following rising edge carries a tick
   task automatic align();
      @(negedge clk);
      while (tick_i !== 1'b1) @(negedge clk);
   endtask

   task automatic ack();
      @(negedge clk);
      rd_ack_i = 1'b1;
      @(negedge clk);
      rd_ack_i = 1'b0;
   endtask

   task automatic send_raw(input logic [7:0] d, input int n,
                           input bit pen, input bit pval,
                           input int stops, input bit stop0);
      rx_i = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < n; i++) begin
         rx_i = d[i];
         wait_clk(BIT_CLK);
      end
      if (pen) begin
         rx_i = pval;
         wait_clk(BIT_CLK);
      end
      for (int s = 0; s < stops; s++) begin
         rx_i = ~stop0;
         wait_clk(BIT_CLK);
      end
      rx_i = 1'b1;
   endtask

   task automatic cfg(input int n, input bit pen, input bit pt,
                      input int stops);
      data_bit_num_i = 2'(n - 5);
      parity_en_i    = pen;
      parity_type_i  = pt;
      stop_bit_num_i = (stops == 2);
   endtask

   task automatic send(input logic [7:0] d, input int n,
                       input bit pen, input bit pt, input bit flip,
                       input int stops, input bit stop0);
      logic [7:0] m;
      m = 8'hFF >> (8 - n);
      cfg(n, pen, pt, stops);
      align();
      send_raw(d, n, pen, (^(d & m)) ^ pt ^ flip, stops, stop0);
      wait_clk(4);
   endtask

   initial begin
      reset = 1'b1;
      rx_en_i = 1'b1;
      rx_i = 1'b1;
      rd_ack_i = 1'b0;
      cfg(8, 0, 0, 1);
      wait_clk(3);
      chk("rst_data", data_o, 8'h00);
      chk("rst_valid", data_valid_o, 1'b0);
      chk("rst_done", rx_done_o, 1'b0);
      chk("rst_flags", {parity_err_o, frame_err_o, overrun_err_o}, 3'b000);
      chk("rst_rts", rts_no, 1'b1);
      reset = 1'b0;
      wait_clk(3);
      chk("rts_ready", rts_no, 1'b0);

      // 8N1 0xA5
      push(8'hA5, 0, 0, 0);
      send(8'hA5, 8, 0, 0, 0, 1, 0);
      chk("8n1_valid", data_valid_o, 1'b1);
      chk("8n1_rts", rts_no, 1'b1);
      chk("8n1_data", data_o, 8'hA5);
      ack();
      chk("8n1_ack_valid", data_valid_o, 1'b0);
      wait_clk(2);
      chk("8n1_ack_rts", rts_no, 1'b0);

      // 7E2 good then flipped parity
      push(8'h35, 0, 0, 0);
      send(8'h35, 7, 1, 0, 0, 2, 0);
      ack();
      push(8'h35, 1, 0, 0);
      send(8'h35, 7, 1, 0, 1, 2, 0);
      chk("7e2_perr", parity_err_o, 1'b1);
      ack();

      // 5N1 with the stop bit forced low
      push(8'h1F, 0, 1, 0);
      send(8'h1F, 5, 0, 0, 0, 1, 1);
      chk("5n1_ferr", frame_err_o, 1'b1);
      ack();

      // break: line low for 20 bit times
      cfg(8, 0, 0, 1);
      d0 = done_cnt;
      push(8'h00, 0, 1, 0);
      align();
      rx_i = 1'b0;
      wait_clk(20 * BIT_CLK);
      rx_i = 1'b1;
      wait_clk(2 * BIT_CLK);
      chk("break_once", 8'(done_cnt - d0), 8'd1);
      ack();

      // overrun
      push(8'h11, 0, 0, 0);
      send(8'h11, 8, 0, 0, 0, 1, 0);
      push(8'h11, 0, 0, 1);
      send(8'h22, 8, 0, 0, 0, 1, 0);
      chk("ovr_data", data_o, 8'h11);
      chk("ovr_flag", overrun_err_o, 1'b1);
      ack();
      chk("ovr_ack_valid", data_valid_o, 1'b0);
      chk("ovr_ack_flag", overrun_err_o, 1'b0);

      // ack in the completion cycle of a second frame
      push(8'h33, 0, 0, 0);
      send(8'h33, 8, 0, 0, 0, 1, 0);
      push(8'h44, 0, 0, 0);
      align();
      fork
         send_raw(8'h44, 8, 0, 0, 1, 0);
         begin
            wait_clk(608);
            rd_ack_i = 1'b1;
            @(negedge clk);
            rd_ack_i = 1'b0;
         end
      join
      wait_clk(4);
      chk("ackc_data", data_o, 8'h44);
      chk("ackc_valid", data_valid_o, 1'b1);
      chk("ackc_ovr", overrun_err_o, 1'b0);
      ack();

      // 4-tick low glitch
      d0 = done_cnt;
      align();
      rx_i = 1'b0;
      wait_clk(16);
      rx_i = 1'b1;
      wait_clk(2 * BIT_CLK);
      chk("glitch_none", 8'(done_cnt - d0), 8'd0);

      // receiver disabled mid-data
      d0 = done_cnt;
      fork
         send(8'h5C, 8, 0, 0, 0, 1, 0);
         begin
            wait_clk(200);
            rx_en_i = 1'b0;
            wait_clk(3);
            chk("dis_rts", rts_no, 1'b1);
         end
      join
      wait_clk(BIT_CLK);
      rx_en_i = 1'b1;
      wait_clk(BIT_CLK);
      chk("dis_none", 8'(done_cnt - d0), 8'd0);

      // reset mid-frame while a byte is held
      push(8'h5A, 0, 0, 0);
      send(8'h5A, 8, 0, 0, 0, 1, 0);
      fork
         send(8'h77, 8, 0, 0, 0, 1, 0);
         begin
            wait_clk(300);
            reset = 1'b1;
            #1;
            chk("arst_data", data_o, 8'h00);
            chk("arst_valid", data_valid_o, 1'b0);
            chk("arst_rts", rts_no, 1'b1);
            chk("arst_flags",
                {rx_done_o, parity_err_o, frame_err_o, overrun_err_o},
                4'b0000);
         end
      join
      wait_clk(4);
      reset = 1'b0;
      wait_clk(2 * BIT_CLK);

      chk("sb_drained", 8'(sbq.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
